// File: rtl/busca_instrucao_if.sv
// Instruction-side bus of the nRisc fetch unit:
// memory read port, decode handshake and control-unit hooks.
interface busca_instrucao_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);

  logic               im_req;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_data;

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc_instr;
  logic               instr_valid;
  logic               instr_ready;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               encerra;
  logic               halted;

  modport master (
    output im_req,
    output im_addr,
    input  im_data,
    output instr,
    output pc_instr,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_addr,
    input  encerra,
    output halted
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_data,
    input  instr,
    input  pc_instr,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_addr,
    output encerra,
    input  halted
  );

endinterface

// File: rtl/busca_instrucao.sv
// nRisc instruction fetch: PC walk, 2-entry queue,
// epoch-tagged responses, redirect and halt handling.
module busca_instrucao #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  busca_instrucao_if.master  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  fetch_pc_next;
  logic               epoch;
  logic               epoch_next;

  logic               inflight;
  logic               inflight_next;
  logic               inflight_tag;
  logic               inflight_tag_next;
  logic [ADDR_W-1:0]  inflight_addr;
  logic [ADDR_W-1:0]  inflight_addr_next;

  logic [INSTR_W-1:0] q_data [2];
  logic [ADDR_W-1:0]  q_addr [2];
  logic               head;
  logic               head_next;
  logic [1:0]         count;
  logic [1:0]         count_next;
  logic               tail;

  logic               run;
  logic               pop;
  logic               req;
  logic               tag_ok;
  logic               write;
  logic [2:0]         credit;

  // Handshake, credit and request decode; outputs
  // never depend on the arriving byte (no bypass).
  always_comb begin
    run    = (state == RUN);
    pop    = run && (count != 2'd0) && bus.instr_ready;
    credit = {1'b0, count}
           + {2'b00, inflight}
           - {2'b00, pop};
    req    = run && !reset
           && !bus.redirect && !bus.encerra
           && (credit < 3'd2);
    tag_ok = inflight && (inflight_tag == epoch);
    tail   = head ^ count[0];

    bus.im_req      = req;
    bus.im_addr     = fetch_pc;
    bus.instr       = q_data[head];
    bus.pc_instr    = q_addr[head];
    bus.instr_valid = run && (count != 2'd0);
    bus.halted      = !run;
  end

  // Next-state: halt beats redirect, redirect
  // flushes even a same-cycle pop or arrival.
  always_comb begin
    state_next         = state;
    fetch_pc_next      = fetch_pc;
    epoch_next         = epoch;
    inflight_next      = 1'b0;
    inflight_tag_next  = inflight_tag;
    inflight_addr_next = inflight_addr;
    head_next          = head;
    count_next         = count;
    write              = 1'b0;

    unique case (1'b1)
      !run: begin
        state_next = HALT;
        count_next = 2'd0;
      end
      run && bus.encerra: begin
        state_next = HALT;
        count_next = 2'd0;
      end
      run && !bus.encerra && bus.redirect: begin
        count_next    = 2'd0;
        epoch_next    = !epoch;
        fetch_pc_next = bus.redirect_addr;
      end
      default: begin
        write              = tag_ok;
        head_next          = head ^ pop;
        count_next         = count
                           + {1'b0, write}
                           - {1'b0, pop};
        inflight_next      = req;
        inflight_tag_next  = epoch;
        inflight_addr_next = fetch_pc;
        fetch_pc_next      = fetch_pc
                           + {{(ADDR_W-1){1'b0}}, req};
      end
    endcase
  end

  // Control state, PC, epoch and queue pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      fetch_pc      <= '0;
      epoch         <= 1'b0;
      inflight      <= 1'b0;
      inflight_tag  <= 1'b0;
      inflight_addr <= '0;
      head          <= 1'b0;
      count         <= 2'd0;
    end else begin
      state         <= state_next;
      fetch_pc      <= fetch_pc_next;
      epoch         <= epoch_next;
      inflight      <= inflight_next;
      inflight_tag  <= inflight_tag_next;
      inflight_addr <= inflight_addr_next;
      head          <= head_next;
      count         <= count_next;
    end
  end

  // Queue storage: accepted response lands at tail.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_addr[0] <= '0;
      q_addr[1] <= '0;
    end else if (write) begin
      q_data[tail] <= bus.im_data;
      q_addr[tail] <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: queue-level reference
// model checked every cycle plus directed scenarios.
module tb_busca_instrucao;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  busca_instrucao_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  busca_instrucao #(.ADDR_W(8), .INSTR_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mv(input logic [7:0] a);
    return (a < 8'h10) ? a : (a ^ 8'hA5);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pc(input logic [7:0] pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.instr_valid && bus.pc_instr == pc) found = 1'b1;
      else cyc();
    end
    chk("wait_pc", {31'b0, found}, 32'd1);
  endtask

  // synchronous instruction memory, garbage when idle
  initial forever begin
    @(posedge clock);
    bus.im_data <= bus.im_req ? mv(bus.im_addr) : 8'hEE;
  end

  // reference model: queue of addresses + one pending read
  logic [7:0] m_q [$];
  logic       m_halt     = 1'b0;
  logic [7:0] m_pc       = 8'h00;
  logic       m_inf      = 1'b0;
  logic [7:0] m_inf_addr = 8'h00;

  initial forever begin
    logic ev, er, pop;
    @(negedge clock);
    if (reset) begin
      chk("rst_im_req", bus.im_req, 0);
      chk("rst_im_addr", bus.im_addr, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_pc_instr", bus.pc_instr, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_halted", bus.halted, 0);
      m_q.delete();
      m_halt = 1'b0;
      m_pc   = 8'h00;
      m_inf  = 1'b0;
    end else begin
      ev  = !m_halt && (m_q.size() > 0);
      pop = ev && bus.instr_ready;
      er  = !m_halt && !bus.redirect && !bus.encerra
         && ((m_q.size() + int'(m_inf) - int'(pop)) < 2);
      chk("m_valid", bus.instr_valid, ev);
      chk("m_im_req", bus.im_req, er);
      chk("m_halted", bus.halted, m_halt);
      if (ev) begin
        chk("m_pc_instr", bus.pc_instr, m_q[0]);
        chk("m_instr", bus.instr, mv(m_q[0]));
      end
      if (er) chk("m_im_addr", bus.im_addr, m_pc);
      if (m_halt) begin
        m_inf = 1'b0;
      end else if (bus.encerra) begin
        m_halt = 1'b1;
        m_q.delete();
        m_inf = 1'b0;
      end else if (bus.redirect) begin
        m_q.delete();
        m_inf = 1'b0;
        m_pc  = bus.redirect_addr;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_addr);
        m_inf      = er;
        m_inf_addr = m_pc;
        if (er) m_pc = m_pc + 8'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [7:0] held;

  initial begin
    bus.instr_ready   = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 8'h00;
    bus.encerra       = 1'b0;
    reset             = 1'b1;
    cyc();
    cyc();
    chk("reset_req", bus.im_req, 0);
    chk("reset_halted", bus.halted, 0);

    // streaming
    reset = 1'b0;
    #1;
    chk("first_req", bus.im_req, 1);
    chk("first_addr", bus.im_addr, 8'h00);
    cyc();
    chk("lat_n1_valid", bus.instr_valid, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stream_valid", bus.instr_valid, 1);
      chk("stream_pc", bus.pc_instr, i);
      chk("stream_instr", bus.instr, i);
      cyc();
    end

    // redirect at pc 5 to 0x40
    wait_pc(8'h05);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h40;
    cyc();
    bus.redirect = 1'b0;
    chk("redir_r1_valid", bus.instr_valid, 0);
    chk("redir_r1_addr", bus.im_addr, 8'h40);
    cyc();
    chk("redir_r2_valid", bus.instr_valid, 0);
    cyc();
    chk("redir_pc40", bus.pc_instr, 8'h40);
    chk("redir_instr40", bus.instr, 8'hE5);
    cyc();
    chk("redir_pc41", bus.pc_instr, 8'h41);
    chk("redir_instr41", bus.instr, 8'hE4);
    cyc();

    // backpressure for 5 cycles
    held = bus.pc_instr;
    chk("bp_start_pc", held, 8'h42);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_pc", bus.pc_instr, held);
      chk("bp_hold_instr", bus.instr, mv(held));
      if (i == 4) chk("bp_no_req", bus.im_req, 0);
      cyc();
    end
    bus.instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_resume_pc", bus.pc_instr, held + i[7:0]);
      cyc();
    end

    // wrap-around
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'hFE;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    cyc();
    chk("wrap_pcfe", bus.pc_instr, 8'hFE);
    chk("wrap_instrfe", bus.instr, 8'h5B);
    cyc();
    chk("wrap_pcff", bus.pc_instr, 8'hFF);
    chk("wrap_instrff", bus.instr, 8'h5A);
    cyc();
    chk("wrap_pc00", bus.pc_instr, 8'h00);
    chk("wrap_instr00", bus.instr, 8'h00);

    // reset with a full queue
    bus.instr_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("full_valid", bus.instr_valid, 1);
    chk("full_no_req", bus.im_req, 0);
    reset = 1'b1;
    #1;
    chk("amid_valid", bus.instr_valid, 0);
    chk("amid_req", bus.im_req, 0);
    chk("amid_pc", bus.pc_instr, 0);
    chk("amid_instr", bus.instr, 0);
    cyc();
    reset           = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("post_rst_req", bus.im_req, 1);
    chk("post_rst_addr", bus.im_addr, 8'h00);
    cyc();
    cyc();
    chk("post_rst_valid", bus.instr_valid, 1);
    chk("post_rst_pc", bus.pc_instr, 8'h00);

    // halt with simultaneous redirect
    wait_pc(8'h03);
    bus.encerra       = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h80;
    cyc();
    bus.encerra  = 1'b0;
    bus.redirect = 1'b0;
    chk("halt_halted", bus.halted, 1);
    chk("halt_valid", bus.instr_valid, 0);
    for (int i = 0; i < 20; i++) begin
      bus.redirect      = (i < 3);
      bus.redirect_addr = 8'h10;
      chk("halt_no_req", bus.im_req, 0);
      cyc();
    end
    bus.redirect = 1'b0;
    chk("halt_stays", bus.halted, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
